// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single D-cache port between MEM-stage loads and store-buffer drains.
// Optional build macro SB_FULL_PRIORITY_EN: a full store buffer gives the head store priority.
module dcache_port_arbiter #(
  parameter int WORD_SIZE        = 32,
  parameter int WIDTH            = 32,
  parameter int ROB_ENTRY_WIDTH  = 3,
  parameter int SIZE_WRITE_WIDTH = 2,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_req,
  input  logic [WIDTH-1:0]            ld_addr,
  input  logic [SIZE_WRITE_WIDTH-1:0] ld_size,
  input  logic [ROB_ENTRY_WIDTH-1:0]  ld_rob_id,
  output logic                        ld_grant,
  input  logic                        sb_valid,
  input  logic                        sb_full,
  input  logic [WIDTH-1:0]            sb_addr,
  input  logic [WORD_SIZE-1:0]        sb_value,
  input  logic [SIZE_WRITE_WIDTH-1:0] sb_size,
  output logic                        sb_pop,
  input  logic                        flush,
  input  logic                        cache_ready,
  output logic                        cache_req,
  output logic                        cache_wenable,
  output logic [WIDTH-1:0]            cache_addr,
  output logic [WORD_SIZE-1:0]        cache_wdata,
  output logic [SIZE_WRITE_WIDTH-1:0] cache_size,
  output logic [ROB_ENTRY_WIDTH-1:0]  cache_rob_id,
  output logic                        starving
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LD   = 2'd1,
    ST   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             port_free;
  logic             flush_kill;
  logic             store_prio;
  logic             st_win;
  logic             ld_win;

`ifdef SB_FULL_PRIORITY_EN
  assign store_prio = sb_full & sb_valid;
`else
  logic unused_sb_full;
  assign unused_sb_full = sb_full;
  assign store_prio     = 1'b0;
`endif

  assign starving = (starve_cnt == CNT_MAX);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    port_free  = 1'b0;
    flush_kill = 1'b0;
    st_win     = 1'b0;
    ld_win     = 1'b0;
    port_free  = (state == IDLE) || cache_ready;
    flush_kill = (state == LD) && flush && !cache_ready;
    // Grants are gated by reset so requesters see no pop/ack while the port is held in reset.
    if (rst && port_free) begin
      if (sb_valid && (starving || store_prio || !ld_req)) begin
        st_win = 1'b1;
      end else if (ld_req) begin
        ld_win = 1'b1;
      end
    end
  end

  assign ld_grant = ld_win;
  assign sb_pop   = st_win;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cache_req     <= 1'b0;
      cache_wenable <= 1'b0;
      cache_addr    <= '0;
      cache_wdata   <= '0;
      cache_size    <= '0;
      cache_rob_id  <= '0;
    end else if (port_free) begin
      if (st_win) begin
        state         <= ST;
        cache_req     <= 1'b1;
        cache_wenable <= 1'b1;
        cache_addr    <= sb_addr;
        cache_wdata   <= sb_value;
        cache_size    <= sb_size;
        cache_rob_id  <= '0;
      end else if (ld_win) begin
        state         <= LD;
        cache_req     <= 1'b1;
        cache_wenable <= 1'b0;
        cache_addr    <= ld_addr;
        cache_wdata   <= '0;
        cache_size    <= ld_size;
        cache_rob_id  <= ld_rob_id;
      end else begin
        state         <= IDLE;
        cache_req     <= 1'b0;
        cache_wenable <= 1'b0;
        cache_addr    <= '0;
        cache_wdata   <= '0;
        cache_size    <= '0;
        cache_rob_id  <= '0;
      end
    end else if (flush_kill) begin
      // A flushed load that the cache never took is simply withdrawn; stores are never killed.
      state     <= IDLE;
      cache_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!sb_valid || st_win) begin
      starve_cnt <= '0;
    end else if (ld_win && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule
